// File: rtl/seq_pkg.sv
// Shared types for the serial stimulus transmitter and the sequence detector:
// serializer FSM encoding, detector state constants and the detector next-state function.
package seq_pkg;

   localparam int unsigned SEQ_LEN_DEF = 64;

   typedef enum logic [1:0] {StIdle, StShift, StDone} ser_state_e;

   typedef enum logic [2:0] {DetS0, DetS1, DetS2, DetS3, DetS4, DetS5, DetS6} det_state_e;

   function automatic det_state_e det_next(input det_state_e s, input logic b);
      det_state_e n;
      unique case (s)
         DetS0:   n = b ? DetS4 : DetS1;
         DetS1:   n = b ? DetS4 : DetS2;
         DetS2:   n = b ? DetS3 : DetS1;
         DetS3:   n = b ? DetS5 : DetS1;
         DetS4:   n = b ? DetS5 : DetS1;
         DetS5:   n = b ? DetS4 : DetS6;
         DetS6:   n = b ? DetS4 : DetS1;
         default: n = DetS0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/seq_hit_model.sv
// Reference model of the lab sequence detector: follows every transmitted bit and counts
// entries into the detecting states S3 and S6.
module seq_hit_model import seq_pkg::*; #(
   parameter int unsigned LEN_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic [LEN_W-1:0] hits
);

   det_state_e       st_q, st_d;
   logic [LEN_W-1:0] hits_q, hits_d;

   always_comb begin
      st_d   = st_q;
      hits_d = hits_q;
      if (clr) begin
         st_d   = DetS0;
         hits_d = '0;
      end else if (bit_valid) begin
         st_d = det_next(st_q, bit_in);
         if (st_d == DetS3 || st_d == DetS6) begin
            hits_d = hits_q + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q   <= DetS0;
         hits_q <= '0;
      end else begin
         st_q   <= st_d;
         hits_q <= hits_d;
      end
   end

   assign hits = hits_q;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial stimulus transmitter for the sequence detector, MSB-first.
// Define SEQ_HIT_MODEL_EN to add the detector model and the exp_hits output.
module seq_serializer import seq_pkg::*; #(
   parameter int unsigned SEQ_LEN = SEQ_LEN_DEF,
   parameter int unsigned LEN_W   = $clog2(SEQ_LEN) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [SEQ_LEN-1:0] load_seq,
   input  logic [LEN_W-1:0]   load_len,
   output logic               x,
   output logic               x_valid,
   output logic               busy,
   output logic               done
`ifdef SEQ_HIT_MODEL_EN
   ,
   output logic [LEN_W-1:0]   exp_hits
`endif
);

   localparam logic [LEN_W-1:0] SeqLenW = LEN_W'(SEQ_LEN);

   ser_state_e         state_q, state_d;
   logic [SEQ_LEN-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d, len_eff;
   logic               x_q, x_d, x_valid_q, x_valid_d;
   logic               busy_q, busy_d, done_q, done_d, ready_q, ready_d;
   logic               accept, shift_bit;

   assign accept    = (state_q == StIdle) && load_valid && ready_q;
   assign shift_bit = (state_q == StShift) && (cnt_q != len_q);
   assign len_eff   = (load_len == '0 || load_len > SeqLenW) ? SeqLenW : load_len;

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      ready_d   = ready_q;
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StShift;
               // Left-align so the first bit to send always sits at the MSB.
               shreg_d = load_seq << (SeqLenW - len_eff);
               len_d   = len_eff;
               cnt_d   = '0;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end
         end
         StShift: begin
            if (shift_bit) begin
               x_d       = shreg_q[SEQ_LEN-1];
               x_valid_d = 1'b1;
               shreg_d   = {shreg_q[SEQ_LEN-2:0], 1'b0};
               cnt_d     = cnt_q + LEN_W'(1);
            end else begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
      end
   end

   assign x          = x_q;
   assign x_valid    = x_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign load_ready = ready_q;

`ifdef SEQ_HIT_MODEL_EN
   seq_hit_model #(
      .LEN_W (LEN_W)
   ) u_hit_model (
      .clk       (clk),
      .rst       (rst),
      .clr       (accept),
      .bit_valid (shift_bit),
      .bit_in    (shreg_q[SEQ_LEN-1]),
      .hits      (exp_hits)
   );
`endif

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: vector table plus reset and back-to-back sequences.
// Checks exp_hits only when SEQ_HIT_MODEL_EN is defined.
module tb_seq_serializer;

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [63:0] load_seq;
   logic [6:0]  load_len;
   logic        x;
   logic        x_valid;
   logic        busy;
   logic        done;
`ifdef SEQ_HIT_MODEL_EN
   logic [6:0]  exp_hits;
`endif

   int total = 0;
   int bad   = 0;

   seq_serializer #(
      .SEQ_LEN (64),
      .LEN_W   (7)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_seq   (load_seq),
      .load_len   (load_len),
      .x          (x),
      .x_valid    (x_valid),
      .busy       (busy),
      .done       (done)
`ifdef SEQ_HIT_MODEL_EN
      ,
      .exp_hits   (exp_hits)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] seq;
      logic [6:0]  len;
      int          hits;
      string       name;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Follows one pattern from the cycle after its accept edge through the return to idle.
   task automatic observe(input logic [63:0] seq, input logic [6:0] len, input int hits,
                          input string name);
      int          leff;
      int          n;
      logic [63:0] got;
      logic [63:0] expv;
      logic        ctl_ok;
      leff   = (len == 0 || len > 64) ? 64 : int'(len);
      expv   = (leff == 64) ? seq : (seq & ((64'd1 << leff) - 64'd1));
      n      = 0;
      got    = '0;
      ctl_ok = 1'b1;
      for (int k = 1; k <= leff; k++) begin
         tick();
         if (x_valid) begin
            n++;
            got = {got[62:0], x};
         end
         if (done || load_ready || !busy) ctl_ok = 1'b0;
      end
      chk({name, " bits"}, got, expv);
      chk({name, " nvalid"}, 64'(n), 64'(leff));
      chk({name, " ctl during shift"}, 64'(ctl_ok), 64'd1);
      tick();
      chk({name, " done cycle {done,xv,x,busy,rdy}"},
          64'({done, x_valid, x, busy, load_ready}), 64'b10010);
`ifdef SEQ_HIT_MODEL_EN
      chk({name, " exp_hits"}, 64'(exp_hits), 64'(hits));
`else
      if (hits < 0) $display("negative hit count for %s", name);
`endif
      tick();
      chk({name, " idle {done,busy,rdy}"}, 64'({done, busy, load_ready}), 64'b001);
   endtask

   task automatic load(input logic [63:0] seq, input logic [6:0] len, input string name);
      int cyc;
      cyc = 0;
      while (!load_ready && cyc < 300) begin
         tick();
         cyc++;
      end
      chk({name, " ready before load"}, 64'(load_ready), 64'd1);
      load_seq   = seq;
      load_len   = len;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      chk({name, " accept {busy,rdy,xv}"}, 64'({busy, load_ready, x_valid}), 64'b100);
   endtask

   initial begin
      logic saw_done;
      logic rdy_ok;

      vecs[0] = '{64'b0011_0001, 7'd8, 3, "v8"};
      vecs[1] = '{64'b110, 7'd3, 1, "v3"};
      vecs[2] = '{64'b1111, 7'd4, 0, "v4ones"};
      vecs[3] = '{64'h8000_0000_0000_0001, 7'd0, 1, "len0"};
      vecs[4] = '{64'hC000_0000_0000_0000, 7'd100, 1, "len100"};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFD, 7'd2, 0, "len2mask"};
      vecs[6] = '{64'b001_0110, 7'd7, 2, "v7"};

      rst        = 1'b0;
      load_valid = 1'b0;
      load_seq   = '0;
      load_len   = '0;
      tick();
      tick();
      chk("reset {x,xv,busy,done,rdy}", 64'({x, x_valid, busy, done, load_ready}), 64'b00001);
`ifdef SEQ_HIT_MODEL_EN
      chk("reset exp_hits", 64'(exp_hits), 64'd0);
`endif
      rst = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         load(vecs[i].seq, vecs[i].len, vecs[i].name);
         observe(vecs[i].seq, vecs[i].len, vecs[i].hits, vecs[i].name);
      end

      // Asynchronous reset while bit 3 of 8 is on the line.
      load(64'b1011_0011, 7'd8, "midrst");
      tick();
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("midrst async {x,xv,busy,done,rdy}",
          64'({x, x_valid, busy, done, load_ready}), 64'b00001);
`ifdef SEQ_HIT_MODEL_EN
      chk("midrst exp_hits", 64'(exp_hits), 64'd0);
`endif
      @(negedge clk);
      rst      = 1'b1;
      saw_done = 1'b0;
      rdy_ok   = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done) saw_done = 1'b1;
         if (!load_ready || busy || x_valid) rdy_ok = 1'b0;
      end
      chk("midrst no done", 64'(saw_done), 64'd0);
      chk("midrst stays idle", 64'(rdy_ok), 64'd1);
      load(vecs[0].seq, vecs[0].len, "after rst");
      observe(vecs[0].seq, vecs[0].len, vecs[0].hits, "after rst");

      // load_valid held high: second pattern is taken only on the cycle after done.
      load_seq   = 64'b110;
      load_len   = 7'd3;
      load_valid = 1'b1;
      tick();
      chk("b2b first accept {busy,rdy}", 64'({busy, load_ready}), 64'b10);
      load_seq = 64'b0011_0001;
      load_len = 7'd8;
      observe(64'b110, 7'd3, 1, "b2b first");
      tick();
      load_valid = 1'b0;
      chk("b2b second accept {busy,rdy,xv}", 64'({busy, load_ready, x_valid}), 64'b100);
      observe(64'b0011_0001, 7'd8, 3, "b2b second");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
